// File: rtl/mem_stage.sv
// MEM stage: runs loads/stores on the data memory over a req/ready handshake,
// stalls upstream while an access is outstanding, and owns the MEM/WB register.
module mem_stage #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned REG_W   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regWriteM,
  input  logic              memWriteM,
  input  logic [1:0]        resultSrcM,
  input  logic [DATA_W-1:0] aluResM,
  input  logic [DATA_W-1:0] writeDataM,
  input  logic [DATA_W-1:0] PCPlus2M,
  input  logic [REG_W-1:0]  RdM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ready,
  output logic              stallM,
  output logic              memErr,
  output logic              regWriteW,
  output logic [1:0]        resultSrcW,
  output logic [DATA_W-1:0] aluResW,
  output logic [DATA_W-1:0] readDataW,
  output logic [DATA_W-1:0] PCPlus2W,
  output logic [REG_W-1:0]  RdW,
  output logic [DATA_W-1:0] resultW
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  rbuf;

  // Instruction held across the access so DONE writes back what was issued
  logic               h_reg_write;
  logic [1:0]         h_result_src;
  logic [DATA_W-1:0]  h_alu_res;
  logic [DATA_W-1:0]  h_pc_plus2;
  logic [REG_W-1:0]   h_rd;

  logic access_c;

  assign access_c = memWriteM | (resultSrcM == 2'b01);
  assign stallM   = (state == S_WAIT) || ((state == S_IDLE) && access_c);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      rbuf         <= '0;
      memErr       <= 1'b0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      h_reg_write  <= 1'b0;
      h_result_src <= '0;
      h_alu_res    <= '0;
      h_pc_plus2   <= '0;
      h_rd         <= '0;
      regWriteW    <= 1'b0;
      resultSrcW   <= '0;
      aluResW      <= '0;
      readDataW    <= '0;
      PCPlus2W     <= '0;
      RdW          <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (access_c) begin
            state        <= S_WAIT;
            cnt          <= '0;
            dmem_req     <= 1'b1;
            dmem_we      <= memWriteM;
            dmem_addr    <= ADDR_W'(aluResM);
            dmem_wdata   <= writeDataM;
            h_reg_write  <= regWriteM;
            h_result_src <= resultSrcM;
            h_alu_res    <= aluResM;
            h_pc_plus2   <= PCPlus2M;
            h_rd         <= RdM;
            regWriteW    <= 1'b0;
            resultSrcW   <= '0;
            aluResW      <= '0;
            readDataW    <= '0;
            PCPlus2W     <= '0;
            RdW          <= '0;
          end else begin
            regWriteW    <= regWriteM;
            resultSrcW   <= resultSrcM;
            aluResW      <= aluResM;
            readDataW    <= '0;
            PCPlus2W     <= PCPlus2M;
            RdW          <= RdM;
          end
        end
        S_WAIT: begin
          regWriteW  <= 1'b0;
          resultSrcW <= '0;
          aluResW    <= '0;
          readDataW  <= '0;
          PCPlus2W   <= '0;
          RdW        <= '0;
          if (dmem_ready) begin
            rbuf       <= dmem_we ? '0 : dmem_rdata;
            state      <= S_DONE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            rbuf       <= '0;
            memErr     <= 1'b1;
            state      <= S_DONE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          // Access condition deliberately not re-checked: the instruction retires here
          regWriteW  <= h_reg_write;
          resultSrcW <= h_result_src;
          aluResW    <= h_alu_res;
          readDataW  <= rbuf;
          PCPlus2W   <= h_pc_plus2;
          RdW        <= h_rd;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Writeback result mux
  always_comb begin
    resultW = aluResW;
    case (resultSrcW)
      2'b01:   resultW = readDataW;
      2'b10:   resultW = PCPlus2W;
      default: resultW = aluResW;
    endcase
  end

endmodule
